// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding, widths,
// and the memory write-enable level.
package prog_loader_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned IDX_W         = 11;
  localparam int unsigned MAX_WORDS_DEF = 1024;

  // Write-enable level of memory port A (ENB_W in the memory header)
  localparam logic ENB_W = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler: the first byte of a group lands in bits 7:0.
// word_c/word_rdy_c present the completed word in the same cycle the 4th byte is taken.
module word_asm
  import prog_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [BYTE_W-1:0]   in_byte,
  output logic [WORD_W-1:0]   word_c,
  output logic                word_rdy_c
);

  logic [WORD_W-BYTE_W-1:0] shift;
  logic [1:0]               cnt;

  // Three earlier bytes sit in shift; the 4th byte is spliced in on top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
    end else if (en) begin
      shift <= {in_byte, shift[WORD_W-BYTE_W-1:BYTE_W]};
      cnt   <= cnt + 2'd1;
    end
  end

  assign word_c     = {in_byte, shift};
  assign word_rdy_c = en && (cnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed little-endian image into program memory and holds
// the core in reset until every word has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [WORD_W-1:0]  count, count_nx;
  logic               take;
  logic [WORD_W-1:0]  word_c;
  logic               word_rdy_c;

  assign take = in_valid && in_ready;

  word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .en         (take),
    .in_byte    (in_data),
    .word_c     (word_c),
    .word_rdy_c (word_rdy_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    count_nx = count;
    unique case (state)
      ST_IDLE: state_nx = ST_HDR;
      ST_HDR: begin
        if (word_rdy_c) begin
          count_nx = word_c;
          if (word_c == '0)                    state_nx = ST_DONE;
          else if (word_c > WORD_W'(MAX_WORDS)) state_nx = ST_ERR;
          else                                 state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_rdy_c) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        idx_nx = idx + IDX_W'(1);
        if (WORD_W'(idx) + WORD_W'(1) == count) state_nx = ST_DONE;
        else                                   state_nx = ST_DATA;
      end
      ST_DONE: state_nx = ST_DONE;
      ST_ERR:  state_nx = ST_ERR;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      mem_we   <= ~ENB_W;
      mem_addr <= '0;
      mem_data <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      in_ready <= (state_nx == ST_HDR) || (state_nx == ST_DATA);
      mem_we   <= (state_nx == ST_WRITE) ? ENB_W : ~ENB_W;
      if (state == ST_DATA && word_rdy_c) begin
        mem_addr <= BASE_ADDR + WORD_W'({idx, 2'b00});
        mem_data <= word_c;
      end
      core_rst <= (state_nx != ST_DONE);
      done     <= (state_nx == ST_DONE);
      err      <= (state_nx == ST_ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (default base and base 0x100)
// share the same randomized byte stream; a monitor checks every write.
module tb_prog_loader;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready0, mem_we0, core_rst0, done0, err0;
  logic        in_ready1, mem_we1, core_rst1, done1, err1;
  logic [31:0] mem_addr0, mem_data0, mem_addr1, mem_data1;

  wr_t exp0[$];
  wr_t exp1[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  last_we0 = -1;
  bit  spacing_chk = 1'b0;

  prog_loader #(.BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0),
    .core_rst(core_rst0), .done(done0), .err(err0)
  );

  prog_loader #(.BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .core_rst(core_rst1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    wr_t e;
    if (mem_we0 === 1'b1) begin
      if (exp0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_write0: addr %h data %h, want no write", mem_addr0, mem_data0);
      end else begin
        e = exp0.pop_front();
        check("wr0_addr", mem_addr0, e.addr);
        check("wr0_data", mem_data0, e.data);
      end
      if (spacing_chk && last_we0 >= 0) check("we_spacing", 32'(cyc - last_we0), 32'd5);
      last_we0 = cyc;
    end
    if (mem_we1 === 1'b1) begin
      if (exp1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_write1: addr %h data %h, want no write", mem_addr1, mem_data1);
      end else begin
        e = exp1.pop_front();
        check("wr1_addr", mem_addr1, e.addr);
        check("wr1_data", mem_data1, e.data);
      end
    end
  end

  task automatic check_reset_values();
    check("rst_in_ready",  32'(in_ready0), 32'd0);
    check("rst_mem_we",    32'(mem_we0),   32'd0);
    check("rst_mem_addr",  mem_addr0,      32'd0);
    check("rst_mem_data",  mem_data0,      32'd0);
    check("rst_core_rst",  32'(core_rst0), 32'd1);
    check("rst_done",      32'(done0),     32'd0);
    check("rst_err",       32'(err0),      32'd0);
    check("rst1_mem_addr", mem_addr1,      32'd0);
    check("rst1_core_rst", 32'(core_rst1), 32'd1);
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs checked before any clock edge
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one byte (with random idle gaps) until a handshake occurs at a posedge
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit ok;
    bit r;
    int budget;
    ok = 1'b0;
    budget = 100;
    while (!ok) begin
      @(negedge clk);
      if (budget == 0) begin
        vectors++; miscompares++;
        $display("FAIL byte_timeout: in_ready %b, want 1 within 100 cycles", in_ready0);
        return;
      end
      budget--;
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      in_data  = in_valid ? b : 8'($urandom);
      r = in_ready0;
      @(posedge clk);
      ok = in_valid && r;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_pct);
  endtask

  // Reference model: word i lands at base + 4*i, one strobe per word, then done
  task automatic load_image(input logic [31:0] hdr, input logic [31:0] words[$], input int gap_pct);
    last_we0 = -1;
    send_word(hdr, gap_pct);
    #1;
    if (hdr > 32'd1024) begin
      check("err_flag",      32'(err0),      32'd1);
      check("err_core_rst",  32'(core_rst0), 32'd1);
      check("err_in_ready",  32'(in_ready0), 32'd0);
      check("err_done",      32'(done0),     32'd0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        check("err_refuse", 32'(in_ready0), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("err_sticky", 32'(err0), 32'd1);
    end else begin
      if (hdr != 32'd0) begin
        for (int i = 0; i < int'(hdr); i++) begin
          send_word(words[i], gap_pct);
          exp0.push_back('{addr: BASE0 + 32'(4 * i), data: words[i]});
          exp1.push_back('{addr: BASE1 + 32'(4 * i), data: words[i]});
          #1;
          check("we_latency",     32'(mem_we0),   32'd1);
          check("write_in_ready", 32'(in_ready0), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
      end
      check("done_flag",     32'(done0),     32'd1);
      check("done_core_rst", 32'(core_rst0), 32'd0);
      check("done_in_ready", 32'(in_ready0), 32'd0);
      check("done_err",      32'(err0),      32'd0);
      check("done1_flag",    32'(done1),     32'd1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    check("pending_writes0", 32'(exp0.size()), 32'd0);
    check("pending_writes1", 32'(exp1.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] w;
    int n;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;

    do_reset();

    q.delete(); q.push_back(32'hDEAD_BEEF); q.push_back(32'h0000_0013);
    spacing_chk = 1'b1;
    load_image(32'd2, q, 0);
    spacing_chk = 1'b0;

    do_reset();
    q.delete();
    load_image(32'd0, q, 0);

    do_reset();
    load_image(32'd1025, q, 0);

    do_reset();
    q.delete(); q.push_back(32'hDEAD_BEEF); q.push_back(32'h0000_0013);
    load_image(32'd2, q, 50);

    // Reset in the middle of word 1: word 0 already written, 2 bytes of word 1 dropped
    do_reset();
    send_word(32'd2, 0);
    send_word(32'hCAFE_F00D, 0);
    exp0.push_back('{addr: BASE0, data: 32'hCAFE_F00D});
    exp1.push_back('{addr: BASE1, data: 32'hCAFE_F00D});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    in_valid = 1'b0;
    do_reset();
    check("abort_pending0", 32'(exp0.size()), 32'd0);
    check("abort_pending1", 32'(exp1.size()), 32'd0);
    w = $urandom;
    q.delete(); q.push_back(w);
    load_image(32'd1, q, 30);

    do_reset();
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    load_image(32'd3, q, 0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      n = int'($urandom_range(8, 1));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom);
      load_image(32'(n), q, int'($urandom_range(70)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
